// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message-preparation path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sha256_pkg;

    typedef enum logic [2:0] {
        FILL = 3'd0,
        PAD  = 3'd1,
        LEN  = 3'd2,
        WAIT = 3'd3,
        SEND = 3'd4,
        DONE = 3'd5,
        IDLE = 3'd6
    } pad_state_t;

    localparam int          BLK_WORDS   = 16;
    localparam int          LEN_WORD_HI = 14;
    localparam logic [31:0] PAD_MARKER  = 32'h8000_0000;

endpackage

// File: rtl/sha256_pad_word.sv
// Masks a final message word to its valid bytes and inserts the 0x80 marker.
// Latency: combinational.
// Backpressure: none; SHA256_PADDER_BYTE_EN enables byte masking, otherwise words pass through.
module sha256_pad_word (
    input  logic [31:0] word,
    input  logic [2:0]  nbytes,
    output logic [31:0] padded,
    output logic        placed
);

`ifdef SHA256_PADDER_BYTE_EN
    // Keep the leading valid bytes, put the marker in the first free byte.
    always_comb begin
        padded = word;
        placed = 1'b0;
        case (nbytes)
            3'd1: begin padded = {word[31:24], 8'h80, 16'h0000}; placed = 1'b1; end
            3'd2: begin padded = {word[31:16], 8'h80, 8'h00};    placed = 1'b1; end
            3'd3: begin padded = {word[31:8],  8'h80};           placed = 1'b1; end
            default: begin padded = word; placed = 1'b0; end
        endcase
    end
`else
    logic unused_nbytes;
    assign unused_nbytes = ^nbytes;

    // Whole-word messages only: the marker always needs a word of its own.
    always_comb begin
        padded = word;
        placed = 1'b0;
    end
`endif

endmodule

// File: rtl/sha256_padder.sv
// Buffers a 32-bit message stream into 512-bit blocks with SHA-256 padding and feeds the core.
// Latency: blk_start the cycle after the 16th word (first block) or after calcu_rdy; 1 cycle/pad word + 2 for length.
// Backpressure: msg_ready only in FILL; blocks held until calcu_rdy. SHA256_PADDER_BYTE_EN enables byte lengths.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        msg_valid,
    output logic        msg_ready,
    input  logic [31:0] msg_word,
    input  logic        msg_last,
    input  logic [1:0]  msg_bytes,
    output logic        blk_start,
    output logic [31:0] blk_word,
    input  logic        calcu_rdy,
    output logic        msg_done
);

    pad_state_t         state, state_n;
    logic [31:0]        blk_buf [BLK_WORDS];
    logic [3:0]         widx, widx_n;
    logic [3:0]         sidx, sidx_n;
    logic [LEN_W-1:0]   nbytes, nbytes_n;
    logic               first, first_n;
    logic               need_mk, need_mk_n;   // marker still owed to the buffer
    logic               hi_mk, hi_mk_n;       // marker sits in word 14/15: length needs its own block
    logic               pend_len, pend_len_n;
    logic               final_blk, final_n;
    logic               len_ph, len_ph_n;
    logic               pad_hi;
    pad_state_t         send_state;

    logic               wr_en, clr_buf;
    logic [3:0]         wr_idx;
    logic [31:0]        wr_dat;

    logic [2:0]         pw_nb;
    logic [31:0]        pw_word;
    logic               pw_placed;
    logic [63:0]        bitlen;

`ifdef SHA256_PADDER_BYTE_EN
    assign pw_nb = (msg_last && msg_bytes != 2'd0) ? {1'b0, msg_bytes} : 3'd4;
`else
    logic unused_bytes;
    assign unused_bytes = ^msg_bytes;
    assign pw_nb = 3'd4;
`endif

    assign bitlen = {{(61 - LEN_W){1'b0}}, nbytes, 3'b000};

    sha256_pad_word u_pad_word (
        .word   (msg_word),
        .nbytes (pw_nb),
        .padded (pw_word),
        .placed (pw_placed)
    );

    // Next state, buffer write port and core-facing outputs.
    always_comb begin
        state_n    = state;
        widx_n     = widx;
        sidx_n     = 4'd0;
        nbytes_n   = nbytes;
        first_n    = first;
        need_mk_n  = need_mk;
        hi_mk_n    = hi_mk;
        pend_len_n = pend_len;
        final_n    = final_blk;
        len_ph_n   = 1'b0;
        pad_hi     = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = widx;
        wr_dat     = '0;
        clr_buf    = 1'b0;
        msg_ready  = 1'b0;
        blk_start  = 1'b0;
        blk_word   = '0;
        msg_done   = 1'b0;
        // Only the very first block may start without the core being ready.
        send_state = (first || calcu_rdy) ? SEND : WAIT;

        case (state)
            FILL: begin
                msg_ready = 1'b1;
                if (msg_valid) begin
                    wr_en    = 1'b1;
                    wr_dat   = pw_word;
                    widx_n   = widx + 4'd1;
                    nbytes_n = nbytes + LEN_W'(pw_nb);
                    if (!msg_last) begin
                        if (widx == 4'd15) state_n = send_state;
                    end else if (pw_placed) begin
                        if (widx == 4'(LEN_WORD_HI - 1)) begin
                            state_n = LEN;
                        end else if (widx == 4'd15) begin
                            state_n    = send_state;
                            pend_len_n = 1'b1;
                        end else begin
                            state_n = PAD;
                            hi_mk_n = (widx == 4'(LEN_WORD_HI));
                        end
                    end else begin
                        need_mk_n = 1'b1;
                        state_n   = (widx == 4'd15) ? send_state : PAD;
                    end
                end
            end
            PAD: begin
                wr_en     = 1'b1;
                wr_dat    = need_mk ? PAD_MARKER : 32'h0;
                need_mk_n = 1'b0;
                pad_hi    = hi_mk || (need_mk && widx >= 4'(LEN_WORD_HI));
                hi_mk_n   = pad_hi;
                widx_n    = widx + 4'd1;
                if (pad_hi) begin
                    if (widx == 4'd15) begin
                        state_n    = send_state;
                        pend_len_n = 1'b1;
                    end
                end else if (widx == 4'(LEN_WORD_HI - 1)) begin
                    state_n = LEN;
                end
            end
            LEN: begin
                wr_en    = 1'b1;
                wr_idx   = len_ph ? 4'(LEN_WORD_HI + 1) : 4'(LEN_WORD_HI);
                wr_dat   = len_ph ? bitlen[31:0] : bitlen[63:32];
                len_ph_n = ~len_ph;
                if (len_ph) begin
                    state_n = send_state;
                    final_n = 1'b1;
                end
            end
            WAIT: begin
                if (calcu_rdy) state_n = SEND;
            end
            SEND: begin
                blk_word  = blk_buf[sidx];
                blk_start = (sidx == 4'd0);
                sidx_n    = sidx + 4'd1;
                if (sidx == 4'd0) first_n = 1'b0;
                if (sidx == 4'd15) begin
                    clr_buf = 1'b1;
                    widx_n  = 4'd0;
                    if (final_blk) begin
                        state_n = DONE;
                    end else if (pend_len) begin
                        state_n    = LEN;
                        pend_len_n = 1'b0;
                    end else if (need_mk) begin
                        state_n = PAD;
                    end else begin
                        state_n = FILL;
                    end
                end
            end
            DONE: begin
                if (calcu_rdy) begin
                    msg_done = 1'b1;
                    state_n  = IDLE;
                end
            end
            IDLE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Control registers; one message per reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FILL;
            widx      <= '0;
            sidx      <= '0;
            nbytes    <= '0;
            first     <= 1'b1;
            need_mk   <= 1'b0;
            hi_mk     <= 1'b0;
            pend_len  <= 1'b0;
            final_blk <= 1'b0;
            len_ph    <= 1'b0;
        end else begin
            state     <= state_n;
            widx      <= widx_n;
            sidx      <= sidx_n;
            nbytes    <= nbytes_n;
            first     <= first_n;
            need_mk   <= need_mk_n;
            hi_mk     <= hi_mk_n;
            pend_len  <= pend_len_n;
            final_blk <= final_n;
            len_ph    <= len_ph_n;
        end
    end

    // Block buffer: cleared after every sent block so a length-only block starts zeroed.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_buf) begin
            for (int i = 0; i < BLK_WORDS; i++) blk_buf[i] <= '0;
        end else if (wr_en) begin
            blk_buf[wr_idx] <= wr_dat;
        end
    end

endmodule

// File: doc/sha256_padder.md
# sha256_padder

Message-preparation stage directly upstream of the SHA-256 core. Accepts an arbitrary-length big-endian message as a 32-bit word stream and buffers it into 512-bit blocks. Appends FIPS 180-4 padding (0x80 marker, zero fill, 64-bit bit length). Streams each 16-word block into the core's `calcu_en`/`wordIn` port one word per cycle, pacing blocks on the core's `calcu_rdy`.

## Interface
- `LEN_W`, 32: width of the internal byte counter. Maximum message length is 2^LEN_W−1 bytes.
- `clk`  in  1  clock; all state on rising edge
- `rst_n`  in  1  synchronous active-low reset
- `msg_valid`  in  1  `msg_word` valid
- `msg_ready`  out  1  padder accepts a word this cycle
- `msg_word`  in  32  message word, first byte in [31:24]
- `msg_last`  in  1  final word of message
- `msg_bytes`  in  2  valid bytes in the last word: 0=4, 1..3=1..3; MSB-aligned; ignored unless `msg_last`
- `blk_start`  out  1  drives core `calcu_en`; high for exactly one cycle, alongside word 0
- `blk_word`  out  32  drives core `wordIn`
- `calcu_rdy`  in  1  from core: previous block compressed
- `msg_done`  out  1  one-cycle pulse: final block of the message compressed

## Operation
- Storage: 16×32 block buffer, 4-bit write index `widx`, `LEN_W`-bit byte counter `nbytes`, flag `first`.
- Flag `first`: set on reset; cleared by the first `blk_start`.
- State `FILL`:
  - `msg_ready`=1.
  - Each handshake writes `buf[widx]`, `widx`++, `nbytes` += 4 (or `msg_bytes` on last).
  - Bytes beyond `msg_bytes` are zeroed before storage; the 0x80 marker lands in the first free byte.
  - On a non-last handshake at `widx`=15 → `SEND` (full data block).
  - On the last handshake: if the marker fits in this word → go to `PAD` at `widx`+1; if the word is full (4 bytes) → `PAD` writes 0x80000000 first.
- State `PAD`:
  - `msg_ready`=0; writes zero words.
  - When `widx` reaches 14 → `LEN`.
  - If the marker word occupies index 14 or 15: zero-fill through 15, then `SEND`, with a pending-length flag set.
- State `LEN`: writes `buf[14]` = bit length [63:32] and `buf[15]` = bit length [31:0], where bit length = {`nbytes`, 3'b0} zero-extended; then → `SEND` with a final flag set.
- State `SEND`:
  - Entry requires (`first` | `calcu_rdy`); otherwise hold in `WAIT`.
  - Emits `buf[0..15]` over 16 consecutive cycles, with `blk_start`=1 on cycle 0 only.
  - Then: if final → `DONE`; if pending-length → zero the buffer, go to `LEN` (length-only block); else → `FILL` with `widx`=0.
- State `WAIT`: wait for `calcu_rdy`, then `SEND`.
- State `DONE`: wait for `calcu_rdy`, pulse `msg_done`, → `IDLE`.
- State `IDLE`:
  - `msg_ready`=0.
  - Leaves only on reset: the core's hash state is re-initialised only by reset, so one message is handled per reset.
- `nbytes` wraps modulo 2^`LEN_W`. Overlength messages are unsupported; no error is flagged.
- `blk_word` = 0 when not in `SEND`.

## Timing
- Reset values: `msg_ready`=1 (state `FILL`), `blk_start`=0, `blk_word`=0, `msg_done`=0. Buffer, `widx`, `nbytes` and flags cleared; `first`=1.
- `FILL`→`SEND` latency: `blk_start` asserts the cycle after the 16th word handshake (first block), or the cycle after `calcu_rdy` is seen high.
- Padding cost: one cycle per padded word, plus 2 cycles for `LEN`.
- `calcu_rdy` is sampled only in `WAIT`/`DONE` and at `SEND` entry. The core deasserts `calcu_rdy` in response to `calcu_en`; no other acknowledgement is required.
- Reset mid-`SEND` abandons the block: `blk_start`/`blk_word` are 0 the following cycle.
- `msg_valid` is ignored whenever `msg_ready`=0. Words presented while not ready are not consumed.

## Configuration
- Macro: `SHA256_PADDER_BYTE_EN`.
- Defined: byte-granular lengths via `msg_bytes` as above.
- Undefined:
  - `msg_bytes` is ignored and treated as 4; the message is whole words only.
  - The marker always occupies a full word 0x80000000.
  - Byte-masking logic is removed.

## Structure
- Shared package `sha256_pkg`: state enum (`FILL`, `PAD`, `LEN`, `WAIT`, `SEND`, `DONE`, `IDLE`), `BLK_WORDS`=16, `LEN_WORD_HI`=14, `PAD_MARKER`=32'h80000000.
- One sub-module: `sha256_pad_word`. Combinational: word, byte count → masked word with 0x80 marker inserted, plus a "marker placed" flag.

## Test plan
- "abc": `msg_word`=0x61626300, `msg_bytes`=3, `msg_last` → one block: w0=0x61626380, w1..w14=0, w15=0x00000018. Core digest = 0xBA7816BF…
- 14 full words, last on the 14th → block 1: w14=0x80000000, w15=0; block 2: w0..w14=0, w15=0x000001C0. `blk_start` of block 2 waits for `calcu_rdy`.
- 16 full words → block 1 issued without further input; block 2: w0=0x80000000, w15=0x00000200. `msg_done` pulses after the second `calcu_rdy`.
- `msg_valid` toggling every other cycle and `calcu_rdy` held low for 100 cycles → no word lost or duplicated; `blk_start` stays 0 until `calcu_rdy`.
- `rst_n` low during `SEND` cycle 7 → `blk_start`/`blk_word` 0 next cycle; `msg_ready`=1; a subsequent "abc" message is padded correctly.
- Macro undefined: last word with `msg_bytes`=1 → treated as 4 bytes; next word is 0x80000000; length field 32×n.
